keynsham_spislave: RTL and testbench
====================================

# keynsham_spislave

SPI responder (slave) peripheral for the keynsham SoC data bus. It is the far end of the `keynsham_spimaster` link, letting an external SPI master exchange bytes with software running on the oldland CPU. Serial pins are synchronised into `clk` and shifted in SPI mode 0, MSB first, 8-bit frames. Received and transmitted bytes are buffered in small FIFOs exposed as four word registers on the standard peripheral bus port.

## Interface
Parameters:
- `bus_address`, 32'h0: byte base address of the register window.
- `bus_size`, 32'h10: window size in bytes; four words are decoded.
- `fifo_depth`, 4: entries per RX/TX FIFO; power of two, 2..8.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `bus_access` in 1: data bus access strobe.
- `bus_cs` out 1: combinational decode, `bus_addr` inside window.
- `bus_addr` in 30: word address.
- `bus_wr_val` in 32: write data.
- `bus_wr_en` in 1: write when high.
- `bus_bytesel` in 4: byte lanes; only lane 0 is honoured for TX/CTRL.
- `bus_ack` out 1: one-cycle completion pulse.
- `bus_error` out 1: qualifies `bus_ack`.
- `bus_data` out 32: read data; zero whenever `bus_ack` is low (OR-bus).
- `sclk` in 1: SPI clock, asynchronous.
- `mosi` in 1: SPI data in, asynchronous.
- `ncs` in 1: SPI chip select, active-low, asynchronous.
- `miso` out 1: SPI data out; 0 while deselected.

## Operation
- Register map, word offset `bus_addr[1:0]`:
  - 0 RXDATA: read pops the RX head into [7:0]. Empty FIFO returns 0, no error.
  - 1 TXDATA: write pushes [7:0]. Full FIFO drops the byte and responds with ack plus error. Read returns 0.
  - 2 STATUS, read-only: [0] rx_not_empty, [1] tx_not_full, [2] rx_overflow, [3] tx_underflow, [4] selected, [11:8] rx_count, [19:16] tx_count.
  - 3 CTRL, write-1 actions, reads 0: [0] clear rx_overflow, [1] clear tx_underflow, [2] flush both FIFOs.
- Writes to STATUS: ack, no error, ignored.
- Pin input path: `sclk`, `mosi` and `ncs` each pass through 2-flop synchronisers. Edge detect runs on the synchronised `sclk`.
- Shifter FSM states:
  - IDLE: `ncs` high, `miso`=0, bit count 0.
  - LOAD: on `ncs` falling, take the TX head. If TX is empty, load 0x00 and set tx_underflow. Drive bit 7.
  - SHIFT: sample `mosi` on each `sclk` rise. Advance `miso` on each `sclk` fall.
  - End of byte: after the 8th rise, push the byte to RX. If RX is full, drop it and set rx_overflow. Reload the shifter from TX with the same underflow rule; the new bit 7 drives at the next fall.
  - Any state: `ncs` rising aborts to IDLE and discards a partial byte. A reloaded TX byte that was never clocked is lost.
- Simultaneous events:
  - SPI push and bus pop in the same cycle: both succeed, count unchanged.
  - Same for bus push and SPI pop on TX.
  - Flag set and clear in the same cycle: set wins.
  - Flush in the same cycle as a push or pop: flush wins.

## Timing
- Bus: `bus_ack` is registered, high exactly one cycle after a `bus_access && bus_cs` cycle. `bus_data` and `bus_error` are valid only in that cycle.
- Back-to-back accesses are accepted every cycle.
- Pop/push side effects commit on the access cycle edge.
- SPI constraints: `sclk` high and low each ≥ 4 `clk` periods. `ncs` setup to the first `sclk` rise ≥ 4 `clk` periods.
- A received byte is visible in STATUS ≤ 4 `clk` after the 8th pin-level `sclk` rise.
- `miso` updates 3 `clk` after a pin `sclk` fall, and 3 `clk` after an `ncs` fall for bit 7.
- Reset values: `bus_ack`, `bus_error`, `bus_data`, `miso` all 0. Flags cleared, FIFOs empty, FSM in IDLE, synchronisers loaded with `ncs`=1, `sclk`=0.
- Reset mid-frame aborts the frame immediately.

## Structure
- Shared package/header: register offsets, STATUS bit positions, CTRL bit positions.
- Sub-module `keynsham_spislave_fifo`:
  - Parameterised width 8 and depth `fifo_depth`; pointers are log2+1 bits with wrap.
  - Ports: push, pop, flush, full, empty, count, head.
  - Instantiated twice, for RX and TX.
- Top level holds the synchronisers, the shifter FSM and the bus decode.

## Test plan
- Reset, then read STATUS -> 0x00000002. Read RXDATA -> 0, no error.
- Write TX 0xA5, master sends 0x3C -> `miso` carries 0xA5, RXDATA reads 0x3C, rx_count then returns to 0.
- Master sends 5 bytes with `fifo_depth`=4 and no reads -> rx_count=4, rx_overflow=1, RX holds the first 4 bytes. CTRL write 0x1 clears the flag.
- Master clocks a byte with TX empty -> `miso` all zeros, tx_underflow=1. Five TX writes -> the fifth acks with error, tx_count=4.
- `ncs` rises after 5 bits, then a full byte 0x81 -> RX holds only 0x81, bit count restarted.
- Assert `rst_n` low mid-byte with both FIFOs non-empty -> all outputs 0, STATUS reads 0x00000002 after release.

Source files
------------

// File: rtl/keynsham_spislave_pkg.sv
// Shared definitions for the keynsham SPI responder: register offsets,
// STATUS/CTRL bit positions and the shifter state encoding.
package keynsham_spislave_pkg;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_RX_OVERFLOW  = 2;
    localparam int ST_TX_UNDERFLOW = 3;
    localparam int ST_SELECTED     = 4;
    localparam int ST_RX_COUNT     = 8;
    localparam int ST_TX_COUNT     = 16;

    localparam int CTRL_CLR_RX_OVF = 0;
    localparam int CTRL_CLR_TX_UNF = 1;
    localparam int CTRL_FLUSH      = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } shift_state_t;

endpackage

// File: rtl/keynsham_spislave_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; flush overrides push/pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module keynsham_spislave_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/keynsham_spislave.sv
// SPI mode-0 responder with RX/TX byte FIFOs behind a four-word bus window.
// Pins are synchronised into clk; the shifter runs entirely on synchronised edges.
module keynsham_spislave #(
    parameter logic [31:0] bus_address = 32'h0,
    parameter logic [31:0] bus_size    = 32'h10,
    parameter int          fifo_depth  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_access,
    output logic        bus_cs,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_wr_val,
    input  logic        bus_wr_en,
    input  logic [3:0]  bus_bytesel,
    output logic        bus_ack,
    output logic        bus_error,
    output logic [31:0] bus_data,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ncs,
    output logic        miso
);
    import keynsham_spislave_pkg::*;

    localparam int          CW         = $clog2(fifo_depth) + 1;
    localparam logic [29:0] BASE_WORD  = bus_address[31:2];
    localparam logic [29:0] SIZE_WORDS = bus_size[31:2];

    logic [29:0]  word_off;
    logic [1:0]   reg_sel;
    logic         hit, ctrl_wr, flush;
    logic [1:0]   sclk_sync, mosi_sync, ncs_sync;
    logic         sclk_d, sclk_s, mosi_s, ncs_s, sclk_rise, sclk_fall;
    shift_state_t state, state_next;
    logic         load_tx, start, shift_in, shift_out, byte_done;
    logic [2:0]   bit_cnt;
    logic [7:0]   tx_sh, rx_sh, tx_byte, rx_byte;
    logic         rx_pop, rx_full, rx_empty, tx_push, tx_full, tx_empty;
    logic [CW-1:0] rx_count, tx_count;
    logic [7:0]   rx_head, tx_head;
    logic         rx_ovf, tx_unf;
    logic [31:0]  status, rd_mux;
    logic         unused_bits;

    assign word_off    = bus_addr - BASE_WORD;
    assign bus_cs      = (word_off < SIZE_WORDS);
    assign reg_sel     = word_off[1:0];
    assign hit         = bus_access && bus_cs;
    assign rx_pop      = hit && !bus_wr_en && (reg_sel == REG_RXDATA);
    assign tx_push     = hit && bus_wr_en && (reg_sel == REG_TXDATA) && bus_bytesel[0];
    assign ctrl_wr     = hit && bus_wr_en && (reg_sel == REG_CTRL) && bus_bytesel[0];
    assign flush       = ctrl_wr && bus_wr_val[CTRL_FLUSH];
    assign unused_bits = ^{bus_wr_val[31:8], bus_bytesel[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ncs_sync  <= 2'b11;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            ncs_sync  <= {ncs_sync[0], ncs};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ncs_s     = ncs_sync[1];
    assign sclk_rise = sclk_s && !sclk_d;
    assign sclk_fall = !sclk_s && sclk_d;
    assign tx_byte   = tx_empty ? 8'h00 : tx_head;
    assign rx_byte   = {rx_sh[6:0], mosi_s};

    keynsham_spislave_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(byte_done), .pop(rx_pop), .flush(flush),
        .data_in(rx_byte), .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
    );

    keynsham_spislave_fifo #(.WIDTH(8), .DEPTH(fifo_depth)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(load_tx), .flush(flush),
        .data_in(bus_wr_val[7:0]), .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
    );

    // LOAD holds a reloaded byte whose bit 7 is presented on the next sclk fall.
    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        start      = 1'b0;
        shift_in   = 1'b0;
        shift_out  = 1'b0;
        byte_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!ncs_s) begin
                    load_tx    = 1'b1;
                    start      = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_LOAD: begin
                if (ncs_s) begin
                    state_next = S_IDLE;
                end else if (sclk_fall) begin
                    shift_out  = 1'b1;
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ncs_s) begin
                    state_next = S_IDLE;
                end else if (sclk_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        byte_done  = 1'b1;
                        load_tx    = 1'b1;
                        state_next = S_LOAD;
                    end
                end else if (sclk_fall) begin
                    shift_out = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            miso    <= 1'b0;
            bit_cnt <= 3'd0;
        end else begin
            state <= state_next;
            if (state_next == S_IDLE) begin
                miso    <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                if (start)          miso <= tx_byte[7];
                else if (shift_out) miso <= tx_sh[7];
                if (shift_in) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start)          tx_sh <= {tx_byte[6:0], 1'b0};
        else if (load_tx)   tx_sh <= tx_byte;
        else if (shift_out) tx_sh <= {tx_sh[6:0], 1'b0};
        if (shift_in) rx_sh <= rx_byte;
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovf <= 1'b0;
            tx_unf <= 1'b0;
        end else begin
            if (byte_done && rx_full && !rx_pop && !flush)         rx_ovf <= 1'b1;
            else if (ctrl_wr && bus_wr_val[CTRL_CLR_RX_OVF])       rx_ovf <= 1'b0;
            if (load_tx && tx_empty)                               tx_unf <= 1'b1;
            else if (ctrl_wr && bus_wr_val[CTRL_CLR_TX_UNF])       tx_unf <= 1'b0;
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_RX_NOT_EMPTY]      = !rx_empty;
        status[ST_TX_NOT_FULL]       = !tx_full;
        status[ST_RX_OVERFLOW]       = rx_ovf;
        status[ST_TX_UNDERFLOW]      = tx_unf;
        status[ST_SELECTED]          = (state != S_IDLE);
        status[ST_RX_COUNT +: 4]     = 4'(rx_count);
        status[ST_TX_COUNT +: 4]     = 4'(tx_count);
        rd_mux = '0;
        case (reg_sel)
            REG_RXDATA: rd_mux = {24'h0, rx_empty ? 8'h00 : rx_head};
            REG_STATUS: rd_mux = status;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_error <= 1'b0;
            bus_data  <= '0;
        end else begin
            bus_ack   <= hit;
            bus_error <= tx_push && tx_full && !load_tx && !flush;
            bus_data  <= (hit && !bus_wr_en) ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_keynsham_spislave.sv
// Directed bench for keynsham_spislave: bus register accesses plus a bit-banged
// SPI mode-0 master, with hand-computed expected values.
module tb_keynsham_spislave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_access;
    logic        bus_cs;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic        bus_wr_en;
    logic [3:0]  bus_bytesel;
    logic        bus_ack;
    logic        bus_error;
    logic [31:0] bus_data;
    logic        sclk, mosi, ncs, miso;

    int total = 0;
    int bad   = 0;

    keynsham_spislave dut (
        .clk(clk), .rst_n(rst_n), .bus_access(bus_access), .bus_cs(bus_cs),
        .bus_addr(bus_addr), .bus_wr_val(bus_wr_val), .bus_wr_en(bus_wr_en),
        .bus_bytesel(bus_bytesel), .bus_ack(bus_ack), .bus_error(bus_error),
        .bus_data(bus_data), .sclk(sclk), .mosi(mosi), .ncs(ncs), .miso(miso)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic bus_op(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
        @(negedge clk);
        bus_access  = 1'b1;
        bus_addr    = a;
        bus_wr_en   = wr;
        bus_wr_val  = wd;
        bus_bytesel = 4'hF;
        @(posedge clk);
        #1;
        chk("ack", {31'h0, bus_ack}, 32'h1);
        rd          = bus_data;
        err         = bus_error;
        bus_access  = 1'b0;
        bus_wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input logic [29:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        e;
        bus_op(1'b0, a, 32'h0, d, e);
        chk(tag, d, exp);
    endtask

    task automatic wr_chk(input logic [29:0] a, input logic [31:0] v, input logic exp_err,
                          input string tag);
        logic [31:0] d;
        logic        e;
        bus_op(1'b1, a, v, d, e);
        chk(tag, {31'h0, e}, {31'h0, exp_err});
    endtask

    task automatic spi_select();
        @(negedge clk);
        ncs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_deselect();
        repeat (6) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] data, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = data[i];
            repeat (6) @(negedge clk);
            sclk   = 1'b1;
            got[i] = miso;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] got;
        rst_n = 1'b0; bus_access = 1'b0; bus_addr = '0; bus_wr_val = '0;
        bus_wr_en = 1'b0; bus_bytesel = 4'h0; sclk = 1'b0; mosi = 1'b0; ncs = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, bus_ack}, 32'h0);
        chk("rst_err", {31'h0, bus_error}, 32'h0);
        chk("rst_data", bus_data, 32'h0);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rd_chk(30'd2, 32'h0000_0002, "status_reset");
        rd_chk(30'd0, 32'h0000_0000, "rx_empty_read");
        @(posedge clk); #1;
        chk("ack_idle", {31'h0, bus_ack}, 32'h0);
        chk("data_idle", bus_data, 32'h0);
        @(negedge clk);
        bus_addr = 30'd4; bus_access = 1'b1;
        #1 chk("cs_outside", {31'h0, bus_cs}, 32'h0);
        @(posedge clk); #1;
        chk("ack_outside", {31'h0, bus_ack}, 32'h0);
        bus_access = 1'b0;

        // single byte exchange
        wr_chk(30'd1, 32'h0000_00A5, 1'b0, "tx_wr_a5");
        rd_chk(30'd2, 32'h0001_0002, "status_tx1");
        spi_select();
        spi_bits(8'h3C, 8, got);
        spi_deselect();
        chk("miso_a5", {24'h0, got}, 32'h0000_00A5);
        rd_chk(30'd2, 32'h0000_010B, "status_rx1");
        rd_chk(30'd0, 32'h0000_003C, "rx_3c");
        rd_chk(30'd2, 32'h0000_000A, "status_after_pop");
        wr_chk(30'd3, 32'h0000_0002, 1'b0, "ctrl_clr_unf");
        rd_chk(30'd2, 32'h0000_0002, "status_clean");

        // RX overflow in one five-byte frame, TX empty throughout
        spi_select();
        spi_bits(8'h11, 8, got); chk("miso_unf0", {24'h0, got}, 32'h0);
        spi_bits(8'h22, 8, got);
        spi_bits(8'h33, 8, got);
        spi_bits(8'h44, 8, got);
        spi_bits(8'h55, 8, got); chk("miso_unf4", {24'h0, got}, 32'h0);
        spi_deselect();
        rd_chk(30'd2, 32'h0000_040F, "status_ovf");
        wr_chk(30'd3, 32'h0000_0001, 1'b0, "ctrl_clr_ovf");
        rd_chk(30'd2, 32'h0000_040B, "status_ovf_clr");
        wr_chk(30'd2, 32'h0000_00FF, 1'b0, "status_write");
        wr_chk(30'd3, 32'h0000_0002, 1'b0, "ctrl_clr_unf2");
        rd_chk(30'd2, 32'h0000_0403, "status_unf_clr");
        rd_chk(30'd0, 32'h0000_0011, "rx_11");
        rd_chk(30'd0, 32'h0000_0022, "rx_22");
        rd_chk(30'd0, 32'h0000_0033, "rx_33");
        rd_chk(30'd0, 32'h0000_0044, "rx_44");
        rd_chk(30'd2, 32'h0000_0002, "status_drained");

        // TX full
        for (int i = 1; i <= 4; i++) wr_chk(30'd1, 32'(i), 1'b0, "tx_fill");
        wr_chk(30'd1, 32'h0000_0005, 1'b1, "tx_full_err");
        rd_chk(30'd2, 32'h0004_0000, "status_tx_full");
        rd_chk(30'd1, 32'h0000_0000, "txdata_read");
        wr_chk(30'd3, 32'h0000_0004, 1'b0, "ctrl_flush");
        rd_chk(30'd2, 32'h0000_0002, "status_flushed");

        // aborted partial byte
        spi_select();
        spi_bits(8'hFF, 5, got);
        spi_deselect();
        spi_select();
        spi_bits(8'h81, 8, got);
        spi_deselect();
        rd_chk(30'd2, 32'h0000_010B, "status_abort");
        rd_chk(30'd0, 32'h0000_0081, "rx_81");
        wr_chk(30'd3, 32'h0000_0002, 1'b0, "ctrl_clr_unf3");

        // two-byte frame, TX reload between bytes
        wr_chk(30'd1, 32'h0000_005A, 1'b0, "tx_wr_5a");
        wr_chk(30'd1, 32'h0000_00C3, 1'b0, "tx_wr_c3");
        spi_select();
        spi_bits(8'h12, 8, got); chk("miso_5a", {24'h0, got}, 32'h0000_005A);
        spi_bits(8'h34, 8, got); chk("miso_c3", {24'h0, got}, 32'h0000_00C3);
        spi_deselect();
        rd_chk(30'd2, 32'h0000_020B, "status_two");
        rd_chk(30'd0, 32'h0000_0012, "rx_12");
        rd_chk(30'd0, 32'h0000_0034, "rx_34");
        wr_chk(30'd3, 32'h0000_0002, 1'b0, "ctrl_clr_unf4");

        // reset in the middle of the second byte of a frame
        wr_chk(30'd1, 32'h0000_00E7, 1'b0, "tx_wr_e7");
        wr_chk(30'd1, 32'h0000_00C0, 1'b0, "tx_wr_c0");
        wr_chk(30'd1, 32'h0000_0011, 1'b0, "tx_wr_11");
        spi_select();
        spi_bits(8'h99, 8, got); chk("miso_e7", {24'h0, got}, 32'h0000_00E7);
        mosi = 1'b1;
        repeat (6) @(negedge clk); sclk = 1'b1;
        repeat (6) @(negedge clk); sclk = 1'b0;
        repeat (6) @(negedge clk); sclk = 1'b1;
        repeat (6) @(negedge clk);
        chk("miso_pre_rst", {31'h0, miso}, 32'h1);
        rd_chk(30'd2, 32'h0001_0113, "status_selected");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", {31'h0, miso}, 32'h0);
        chk("mid_rst_ack", {31'h0, bus_ack}, 32'h0);
        chk("mid_rst_err", {31'h0, bus_error}, 32'h0);
        chk("mid_rst_data", bus_data, 32'h0);
        ncs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd_chk(30'd2, 32'h0000_0002, "status_post_rst");
        rd_chk(30'd0, 32'h0000_0000, "rx_post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
